// File: rtl/sopc_bus_pkg.sv
// Shared types and defaults for the SOPC unified-memory bus.
package sopc_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2
  } arb_state_t;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 16;

  // Value returned to the CPU in place of read data when a transaction is aborted.
  localparam int unsigned BUS_ERR_DATA = 0;

endpackage

// File: rtl/sopc_mem_arbiter_if.sv
// Memory-side handshake of the arbiter: single outstanding request, ack pulse.
interface sopc_mem_arbiter_if
  import sopc_bus_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  localparam int SEL_W = DATA_W / 8;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [SEL_W-1:0]  mem_sel_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_sel_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_sel_o,
    output mem_ack_i, mem_rdata_i
  );

endinterface

// File: rtl/bus_watchdog.sv
// Cycle counter that flags a bus transaction which has waited TIMEOUT cycles.
module bus_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt_q + CNT_W'(1);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create simulation order races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= cnt_inc;
    end
  end

  // Expiry is flagged in the waiting cycle whose increment would reach TIMEOUT,
  // so the request is held for exactly TIMEOUT cycles before the abort.
  generate
    if (TIMEOUT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      assign expired = run & (cnt_inc == CNT_W'(TIMEOUT));
    end
  endgenerate

endmodule

// File: rtl/sopc_mem_arbiter.sv
// Merges the CPU fetch and data ports onto one variable-latency memory,
// stalling the CPU until every enabled port has been served.
module sopc_mem_arbiter
  import sopc_bus_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_ce_i,
  input  logic [ADDR_W-1:0]        i_addr_i,
  output logic [DATA_W-1:0]        i_rdata_o,
  input  logic                     d_ce_i,
  input  logic                     d_we_i,
  input  logic [ADDR_W-1:0]        d_addr_i,
  input  logic [DATA_W-1:0]        d_wdata_i,
  input  logic [DATA_W/8-1:0]      d_sel_i,
  output logic [DATA_W-1:0]        d_rdata_o,
  output logic                     stall_o,
  sopc_mem_arbiter_if.master       mem,
  output logic                     bus_err_o,
  output logic [ADDR_W-1:0]        err_addr_o
);
  localparam int SEL_W = DATA_W / 8;

  arb_state_t        state_q, state_d;
  logic              d_done_q, i_done_q;
  logic              d_pend, i_pend;
  logic              ack, expired, finish, abort;
  logic              issue_d, issue_i, wd_run;
  logic              req_q, we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [SEL_W-1:0]  sel_q;
  logic [DATA_W-1:0] rd_value;

  assign d_pend  = d_ce_i & ~d_done_q;
  assign i_pend  = i_ce_i & ~i_done_q;
  assign stall_o = d_pend | i_pend;

  // An ack only counts against an outstanding request.
  assign ack   = mem.mem_ack_i & req_q;
  assign abort = finish & ~ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    issue_d = 1'b0;
    issue_i = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Data belongs to the older instruction, so it wins arbitration.
        if (d_pend) begin
          state_d = DATA;
          issue_d = 1'b1;
        end else if (i_pend) begin
          state_d = FETCH;
          issue_i = 1'b1;
        end
      end
      DATA, FETCH: begin
        if (ack || expired) begin
          state_d = IDLE;
          finish  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wd_run   = (state_q != IDLE) & ~ack;
  assign rd_value = ack ? mem.mem_rdata_i : DATA_W'(BUS_ERR_DATA);

  bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (issue_d | issue_i),
    .run     (wd_run),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      sel_q      <= '0;
      d_done_q   <= 1'b0;
      i_done_q   <= 1'b0;
      d_rdata_o  <= '0;
      i_rdata_o  <= '0;
      bus_err_o  <= 1'b0;
      err_addr_o <= '0;
    end else begin
      bus_err_o <= 1'b0;

      if (issue_d) begin
        req_q   <= 1'b1;
        we_q    <= d_we_i;
        addr_q  <= d_addr_i;
        wdata_q <= d_wdata_i;
        sel_q   <= d_sel_i;
      end else if (issue_i) begin
        req_q   <= 1'b1;
        we_q    <= 1'b0;
        addr_q  <= i_addr_i;
        sel_q   <= '1;
      end else if (finish) begin
        req_q   <= 1'b0;
      end

      if (finish) begin
        if (state_q == DATA) begin
          d_done_q <= 1'b1;
          // A completed store leaves the load register untouched.
          if (abort || !we_q) d_rdata_o <= rd_value;
        end else begin
          i_done_q  <= 1'b1;
          i_rdata_o <= rd_value;
        end
        if (abort) begin
          bus_err_o  <= 1'b1;
          err_addr_o <= addr_q;
        end
      end else if (!stall_o) begin
        // CPU advances this edge and will present a fresh pair of requests.
        d_done_q <= 1'b0;
        i_done_q <= 1'b0;
      end
    end
  end

  assign mem.mem_req_o   = req_q;
  assign mem.mem_we_o    = we_q;
  assign mem.mem_addr_o  = addr_q;
  assign mem.mem_wdata_o = wdata_q;
  assign mem.mem_sel_o   = sel_q;

endmodule

// File: tb/tb_sopc_mem_arbiter.sv
// Directed bench for sopc_mem_arbiter: vector table plus reset/idle-ack sequences
// against a small latency-programmable memory model.
module tb_sopc_mem_arbiter;

  localparam int BUDGET = 64;

  logic        clk;
  logic        rst;
  logic        i_ce;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        d_ce;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_sel;
  logic [31:0] d_rdata;
  logic        stall;
  logic        bus_err;
  logic [31:0] err_addr;

  sopc_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  sopc_mem_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_ce_i     (i_ce),
    .i_addr_i   (i_addr),
    .i_rdata_o  (i_rdata),
    .d_ce_i     (d_ce),
    .d_we_i     (d_we),
    .d_addr_i   (d_addr),
    .d_wdata_i  (d_wdata),
    .d_sel_i    (d_sel),
    .d_rdata_o  (d_rdata),
    .stall_o    (stall),
    .mem        (bus),
    .bus_err_o  (bus_err),
    .err_addr_o (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  int          mem_lat;
  logic        mem_hang;
  logic        force_ack;
  int          mem_wait;
  logic [31:0] store_word;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h00:  return 32'h3401_1100;
      32'h04:  return 32'h8C22_0040;
      32'h40:  return 32'hCAFE_F00D;
      32'h44:  return 32'h1234_5678;
      default: return 32'h5A5A_5A5A;
    endcase
  endfunction

  assign bus.mem_ack_i   = force_ack |
                           (bus.mem_req_o & ~mem_hang & (mem_wait == mem_lat));
  assign bus.mem_rdata_i = (bus.mem_addr_o == 32'hC0) ? store_word : rom_word(bus.mem_addr_o);

  always @(posedge clk) begin
    if (!bus.mem_req_o || bus.mem_ack_i) mem_wait <= 0;
    else                                 mem_wait <= mem_wait + 1;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      store_word <= '0;
    end else if (bus.mem_ack_i && bus.mem_we_o && bus.mem_addr_o == 32'hC0) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_sel_o[b]) store_word[8*b +: 8] <= bus.mem_wdata_o[8*b +: 8];
    end
  end

  // ---------------- checking ----------------
  int total;
  int bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        i_ce;
    logic [31:0] i_addr;
    logic        d_ce;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_sel;
    int          lat;          // memory wait cycles before ack; negative = never acks
    int          exp_stall;
    int          exp_req;
    int          exp_err;
    int          exp_issues;
    logic [31:0] exp_addr;     // first issued transaction
    logic        exp_we;
    logic [3:0]  exp_sel;
    logic [31:0] exp_wdata;
    logic [31:0] exp_addr2;    // second issued transaction, if any
    logic [31:0] exp_i_rdata;
    logic [31:0] exp_d_rdata;
    logic [31:0] exp_err_addr;
  } vec_t;

  vec_t vecs [8];

  int          obs_stall, obs_req, obs_err, obs_issues, obs_unstable;
  logic [31:0] obs_addr, obs_wdata, obs_addr2;
  logic        obs_we;
  logic [3:0]  obs_sel;

  task automatic run_txn(input vec_t v);
    logic        prev_req;
    logic        done;
    logic [31:0] cur_addr, cur_wdata;
    logic        cur_we;
    logic [3:0]  cur_sel;
    @(posedge clk);
    #1;
    mem_lat  = v.lat;
    mem_hang = (v.lat < 0);
    i_ce     = v.i_ce;
    i_addr   = v.i_addr;
    d_ce     = v.d_ce;
    d_we     = v.d_we;
    d_addr   = v.d_addr;
    d_wdata  = v.d_wdata;
    d_sel    = v.d_sel;
    obs_stall = 0; obs_req = 0; obs_err = 0; obs_issues = 0; obs_unstable = 0;
    obs_addr = '0; obs_wdata = '0; obs_addr2 = '0; obs_we = 1'b0; obs_sel = '0;
    cur_addr = '0; cur_wdata = '0; cur_we = 1'b0; cur_sel = '0;
    prev_req = 1'b0;
    done     = 1'b0;
    for (int c = 0; c < BUDGET; c++) begin
      @(negedge clk);
      if (bus.mem_req_o && !prev_req) begin
        obs_issues++;
        cur_addr  = bus.mem_addr_o;
        cur_we    = bus.mem_we_o;
        cur_sel   = bus.mem_sel_o;
        cur_wdata = bus.mem_wdata_o;
        if (obs_issues == 1) begin
          obs_addr = cur_addr; obs_we = cur_we; obs_sel = cur_sel; obs_wdata = cur_wdata;
        end else begin
          obs_addr2 = cur_addr;
        end
      end else if (bus.mem_req_o &&
                   ({bus.mem_addr_o, bus.mem_we_o, bus.mem_sel_o, bus.mem_wdata_o} !==
                    {cur_addr, cur_we, cur_sel, cur_wdata})) begin
        obs_unstable++;
      end
      prev_req = bus.mem_req_o;
      if (bus.mem_req_o) obs_req++;
      if (bus_err) obs_err++;
      if (stall) obs_stall++;
      else begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL stall_release_timeout: stall_o still %b after %0d cycles, required 0", stall, BUDGET);
      rst = 1'b0;
      i_ce = 1'b0; d_ce = 1'b0; d_we = 1'b0;
      @(negedge clk);
      rst = 1'b1;
    end else begin
      assert (!(rst && stall)) else $error("protocol: request withdrawn while stall_o high");
      i_ce = 1'b0; d_ce = 1'b0; d_we = 1'b0;
    end
    @(negedge clk);
    if (bus_err) obs_err++;
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    check({tag, "_stall"},    32'(obs_stall),    32'(v.exp_stall));
    check({tag, "_req"},      32'(obs_req),      32'(v.exp_req));
    check({tag, "_err"},      32'(obs_err),      32'(v.exp_err));
    check({tag, "_issues"},   32'(obs_issues),   32'(v.exp_issues));
    check({tag, "_addr"},     obs_addr,          v.exp_addr);
    check({tag, "_we"},       32'(obs_we),       32'(v.exp_we));
    check({tag, "_sel"},      32'(obs_sel),      32'(v.exp_sel));
    check({tag, "_wdata"},    obs_wdata,         v.exp_wdata);
    check({tag, "_unstable"}, 32'(obs_unstable), 32'd0);
    check({tag, "_i_rdata"},  i_rdata,           v.exp_i_rdata);
    check({tag, "_d_rdata"},  d_rdata,           v.exp_d_rdata);
    check({tag, "_err_addr"}, err_addr,          v.exp_err_addr);
    if (v.exp_issues == 2) check({tag, "_addr2"}, obs_addr2, v.exp_addr2);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    // Fields: i_ce, i_addr, d_ce, d_we, d_addr, d_wdata, d_sel, lat,
    //         stall, req, err, issues, addr, we, sel, wdata, addr2, i_rdata, d_rdata, err_addr
    vecs[0] = '{1'b1, 32'h00, 1'b0, 1'b0, 32'h00, 32'h0, 4'h0, 0,
                2, 1, 0, 1, 32'h00, 1'b0, 4'hF, 32'h0, 32'h0,
                32'h3401_1100, 32'h0, 32'h0};
    vecs[1] = '{1'b1, 32'h04, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF, 3,
                10, 8, 0, 2, 32'h40, 1'b0, 4'hF, 32'h0, 32'h04,
                32'h8C22_0040, 32'hCAFE_F00D, 32'h0};
    vecs[2] = '{1'b0, 32'h00, 1'b1, 1'b1, 32'hC0, 32'hDEAD_BEEF, 4'h3, 1,
                3, 2, 0, 1, 32'hC0, 1'b1, 4'h3, 32'hDEAD_BEEF, 32'h0,
                32'h8C22_0040, 32'hCAFE_F00D, 32'h0};
    vecs[3] = '{1'b0, 32'h00, 1'b1, 1'b0, 32'hC0, 32'h0, 4'hF, 2,
                4, 3, 0, 1, 32'hC0, 1'b0, 4'hF, 32'h0, 32'h0,
                32'h8C22_0040, 32'h0000_BEEF, 32'h0};
    vecs[4] = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h80, 32'h0, 4'hF, -1,
                17, 16, 1, 1, 32'h80, 1'b0, 4'hF, 32'h0, 32'h0,
                32'h8C22_0040, 32'h0, 32'h80};
    vecs[5] = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h44, 32'h0, 4'hF, 15,
                17, 16, 0, 1, 32'h44, 1'b0, 4'hF, 32'h0, 32'h0,
                32'h8C22_0040, 32'h1234_5678, 32'h80};
    vecs[6] = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h00, 32'h0, 4'h0, 1,
                3, 2, 0, 1, 32'h40, 1'b0, 4'hF, 32'h0, 32'h0,
                32'hCAFE_F00D, 32'h1234_5678, 32'h80};
    vecs[7] = '{1'b1, 32'h00, 1'b0, 1'b0, 32'h00, 32'h0, 4'h0, 0,
                2, 1, 0, 1, 32'h00, 1'b0, 4'hF, 32'h0, 32'h0,
                32'h3401_1100, 32'h0, 32'h0};

    mem_lat   = 0;
    mem_hang  = 1'b0;
    force_ack = 1'b0;
    i_ce = 1'b1; i_addr = '0;
    d_ce = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_sel = '0;

    // Reset state; stall follows its equation even while in reset.
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("rst_stall_req_on", 32'(stall),            32'd1);
    check("rst_mem_req",      32'(bus.mem_req_o),    32'd0);
    check("rst_mem_we",       32'(bus.mem_we_o),     32'd0);
    check("rst_mem_addr",     bus.mem_addr_o,        32'h0);
    check("rst_mem_wdata",    bus.mem_wdata_o,       32'h0);
    check("rst_mem_sel",      32'(bus.mem_sel_o),    32'd0);
    check("rst_bus_err",      32'(bus_err),          32'd0);
    check("rst_err_addr",     err_addr,              32'h0);
    check("rst_i_rdata",      i_rdata,               32'h0);
    check("rst_d_rdata",      d_rdata,               32'h0);
    i_ce = 1'b0;
    #1;
    check("rst_stall_idle",   32'(stall),            32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i]);
      check_vec($sformatf("v%0d", i), vecs[i]);
    end

    // Stray acks with no request outstanding must be ignored.
    force_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("idle_ack_req",   32'(bus.mem_req_o), 32'd0);
      check("idle_ack_stall", 32'(stall),         32'd0);
    end
    force_ack = 1'b0;
    @(negedge clk);
    check("idle_ack_d_rdata", d_rdata,       32'h1234_5678);
    check("idle_ack_i_rdata", i_rdata,       32'hCAFE_F00D);
    check("idle_ack_bus_err", 32'(bus_err),  32'd0);

    // Reset in the middle of a hung fetch.
    @(posedge clk);
    #1;
    mem_hang = 1'b1;
    i_ce     = 1'b1;
    i_addr   = 32'h04;
    repeat (4) @(negedge clk);
    check("midrst_req_before", 32'(bus.mem_req_o), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("midrst_req_drop",   32'(bus.mem_req_o), 32'd0);
    check("midrst_bus_err",    32'(bus_err),       32'd0);
    check("midrst_i_rdata",    i_rdata,            32'h0);
    check("midrst_stall",      32'(stall),         32'd1);
    i_ce     = 1'b0;
    mem_hang = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_txn(vecs[7]);
    check_vec("post_rst", vecs[7]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sopc_mem_arbiter.md
# sopc_mem_arbiter

Two-master, one-slave memory arbiter for the next-generation SOPC: it merges the CPU instruction-fetch port and data port onto a single shared, variable-latency memory. The CPU is held with a stall request until every enabled port has been served. It also has a watchdog that aborts a hung transaction. It sits between the `mips` core and a unified memory, replacing the separate instruction ROM and data RAM paths.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; must be a multiple of 8
- `TIMEOUT`, 16, maximum cycles to wait for `mem_ack_i`; 0 disables the watchdog
- `clk` in 1: the single clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `i_ce_i` in 1: fetch request enable
- `i_addr_i` in ADDR_W: fetch address
- `i_rdata_o` out DATA_W: fetched instruction, registered
- `d_ce_i` in 1: data request enable
- `d_we_i` in 1: data write enable
- `d_addr_i` in ADDR_W: data address
- `d_wdata_i` in DATA_W: data write value
- `d_sel_i` in DATA_W/8: data byte enables
- `d_rdata_o` out DATA_W: load data, registered
- `stall_o` out 1: pipeline stall request to the CPU, combinational
- `mem_req_o` out 1: memory request, registered
- `mem_we_o` out 1: memory write enable
- `mem_addr_o` out ADDR_W: memory address
- `mem_wdata_o` out DATA_W: memory write data
- `mem_sel_o` out DATA_W/8: memory byte enables
- `mem_ack_i` in 1: memory completion pulse
- `mem_rdata_i` in DATA_W: memory read data, valid when `mem_ack_i` is high
- `bus_err_o` out 1: one-cycle pulse when a transaction is aborted by the watchdog
- `err_addr_o` out ADDR_W: address of the last aborted transaction

## Operation
- States and transitions:
  - IDLE: if `d_ce_i & ~d_done`, go to DATA. Else if `i_ce_i & ~i_done`, go to FETCH.
  - DATA and FETCH: return to IDLE on `mem_ack_i` or on watchdog expiry.
- Priority: data always beats fetch, because the data request belongs to the older instruction.
- Issue: on entering DATA or FETCH, register `mem_req_o=1` together with the address, write enable, byte enables and write data. For FETCH, `mem_we_o=0` and `mem_sel_o` is all ones.
- While in DATA or FETCH, all `mem_*_o` outputs hold stable.
- Completion: on `mem_ack_i` with `mem_req_o=1`:
  - `mem_req_o` falls.
  - The matching `*_done` flag is set.
  - A read captures `mem_rdata_i` into `d_rdata_o` or `i_rdata_o`.
  - A write leaves `d_rdata_o` unchanged.
- `mem_ack_i` is ignored while `mem_req_o=0`.
- Stall: `stall_o = (d_ce_i & ~d_done) | (i_ce_i & ~i_done)`.
- Done-flag clearing: at any rising edge with `stall_o=0`, both done flags clear, because the CPU advances and presents new requests.
- The CPU holds the `i_*` and `d_*` inputs stable while `stall_o=1`.
- Watchdog:
  - The counter clears on issue and increments each cycle in DATA or FETCH without an ack.
  - When it reaches `TIMEOUT`, the transaction aborts: `mem_req_o` falls, the done flag is set, the read data register loads 0, `bus_err_o` pulses, and `err_addr_o` loads the address.
  - An ack in the same cycle as expiry wins; no error is raised.

## Timing
- Reset values:
  - State is IDLE.
  - `mem_req_o`, `mem_we_o`, `bus_err_o` are 0.
  - All address, data and sel outputs are 0.
  - Both done flags and the watchdog counter are 0.
  - `stall_o` follows its equation: it is high if a request is enabled during reset.
- Single access with a zero-wait memory (ack in the first `mem_req_o` cycle): `stall_o` is high for exactly 2 cycles.
- Single access with an N-cycle ack: `stall_o` is high for N+2 cycles.
- Fetch and data requested together: data is served first. IDLE re-arbitrates in the cycle after the data ack, so the total stall is (Nd+2)+(Ni+2) cycles.
- Reset asserted mid-transaction: `mem_req_o` drops immediately, with no completion and no error. The memory must tolerate a dropped request.
- `d_ce_i` deasserting while stalled is a CPU protocol violation; behaviour is undefined, and the bench asserts against it.

## Structure
- Package `sopc_bus_pkg` holds:
  - The state enum `arb_state_t` (IDLE, DATA, FETCH).
  - The default widths.
  - The error-data constant `BUS_ERR_DATA=0`.
- One sub-module, `bus_watchdog`: a counter of width `$clog2(TIMEOUT+1)` with `clear` and `run` inputs and an `expired` output. When `TIMEOUT=0`, `expired` is tied to 0.
- All other logic lives in `sopc_mem_arbiter`.

## Test plan
- Reset, then `i_ce_i=1`, `i_addr_i=0x0`, memory acks in the same cycle with data 0x34011100: `stall_o` is high for 2 cycles and `i_rdata_o=0x34011100`.
- Fetch and load together (`d_addr_i=0x40`, `d_sel_i=0xF`), memory with 3-cycle latency: the data transaction is issued first, fetch follows, and `stall_o` is high for 10 cycles.
- Store with `d_sel_i=0x3`, `d_wdata_i=0xDEADBEEF`: `mem_we_o=1`, `mem_sel_o=0x3`, `mem_wdata_o=0xDEADBEEF`, and `d_rdata_o` is unchanged.
- Memory never acks a load at 0x80 with `TIMEOUT=16`: `mem_req_o` falls after 16 cycles, `bus_err_o` pulses once, `err_addr_o=0x80`, `d_rdata_o=0`, and the stall releases.
- `rst` asserted while in FETCH: `mem_req_o=0` immediately, state is IDLE. After release, a fresh fetch behaves as in the first scenario.
